// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot path: screen geometry, plot register
// address, the plot write payload and the blit FSM state encoding.
package vga_pkg;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;

    localparam logic [3:0] VGA_ADDR_PLOT = 4'd0;

    // One plot write: {pad, y, x, reserved, brightness}
    typedef struct packed {
        logic       pad;
        logic [6:0] y;
        logic [7:0] x;
        logic [7:0] rsvd;
        logic [7:0] brightness;
    } plot_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    function automatic plot_word_t pack_plot(input logic [6:0] y,
                                             input logic [7:0] x,
                                             input logic [7:0] b);
        plot_word_t w;
        w.pad        = 1'b0;
        w.y          = y;
        w.x          = x;
        w.rsvd       = 8'h00;
        w.brightness = b;
        return w;
    endfunction

endpackage

// File: rtl/blit_raster_ctr.sv
// Raster-order col/row counter for an IMG_W x IMG_H source image.
// last_c flags the final pixel (col=IMG_W-1, row=IMG_H-1).
module blit_raster_ctr #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_c
);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    assign last_c = (col == COL_MAX) && (row == ROW_MAX);

    // Column wraps at the image width and carries into the row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_blit_master.sv
// Streams a raster-ordered grayscale image into Avalon-MM plot writes at a
// programmable screen origin, clipping off-screen pixels.
// Optional macro VGA_BLIT_SCALE2_EN: each source pixel becomes a 2x2 block.
module vga_blit_master
    import vga_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    output logic        busy,
    output logic        done,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [3:0]  vga_address,
    output logic        vga_write,
    output logic [31:0] vga_writedata,
    input  logic        vga_waitrequest
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    blit_state_t   state, state_d;
    logic [7:0]    x0_q;
    logic [6:0]    y0_q;
    plot_word_t    wdata_q, wdata_d;
    logic          busy_d, done_d, ready_d, write_d;
    logic          org_ld, ctr_clr, ctr_adv;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_c;

    assign vga_address   = VGA_ADDR_PLOT;
    assign vga_writedata = wdata_q;

    blit_raster_ctr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW),
        .RW    (RW)
    ) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clr),
        .advance (ctr_adv),
        .col     (col),
        .row     (row),
        .last_c  (last_c)
    );

`ifdef VGA_BLIT_SCALE2_EN
    // Sub-pixel idx: bit0 = dx, bit1 = dy; write order is idx 0..3
    function automatic logic [3:0] sub_mask(input logic [9:0] bx, input logic [8:0] by);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = ((bx + 10'(i % 2)) < 10'(SCR_W)) && ((by + 9'(i / 2)) < 9'(SCR_H));
        end
        return m;
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic plot_word_t sub_word(input logic [9:0] bx, input logic [8:0] by,
                                            input logic [1:0] idx, input logic [7:0] b);
        return pack_plot(7'(by + 9'(idx[1])), 8'(bx + 10'(idx[0])), b);
    endfunction

    logic [9:0] bx, bx_q, bx_d;
    logic [8:0] by, by_q, by_d;
    logic [7:0] pix_q, pix_d;
    logic [3:0] mask_q, mask_d, fmask, rem_c;
    logic [1:0] sub_c;

    assign bx    = 10'(x0_q) + 10'({col, 1'b0});
    assign by    = 9'(y0_q) + 9'({row, 1'b0});
    assign fmask = sub_mask(bx, by);
    assign sub_c = low_idx(mask_q);
    assign rem_c = mask_q & ~(4'b0001 << sub_c);

    // Per-pixel block origin, brightness and pending sub-pixel mask
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bx_q   <= '0;
            by_q   <= '0;
            pix_q  <= '0;
            mask_q <= '0;
        end else begin
            bx_q   <= bx_d;
            by_q   <= by_d;
            pix_q  <= pix_d;
            mask_q <= mask_d;
        end
    end
`else
    logic [8:0] sx;
    logic [7:0] sy;
    logic       on_c;

    assign sx   = 9'(x0_q) + 9'(col);
    assign sy   = 8'(y0_q) + 8'(row);
    assign on_c = (sx < 9'(SCR_W)) && (sy < 8'(SCR_H));
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next state, datapath controls and next registered outputs
    always_comb begin
        state_d = state;
        wdata_d = wdata_q;
        org_ld  = 1'b0;
        ctr_clr = 1'b0;
        ctr_adv = 1'b0;
`ifdef VGA_BLIT_SCALE2_EN
        bx_d    = bx_q;
        by_d    = by_q;
        pix_d   = pix_q;
        mask_d  = mask_q;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    org_ld  = 1'b1;
                    ctr_clr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pix_valid) begin
`ifdef VGA_BLIT_SCALE2_EN
                    if (fmask != 4'b0000) begin
                        state_d = ST_WRITE;
                        bx_d    = bx;
                        by_d    = by;
                        pix_d   = pix_data;
                        mask_d  = fmask;
                        wdata_d = sub_word(bx, by, low_idx(fmask), pix_data);
                    end else begin
                        ctr_adv = 1'b1;
                        state_d = last_c ? ST_DONE : ST_FETCH;
                    end
`else
                    if (on_c) begin
                        state_d = ST_WRITE;
                        wdata_d = pack_plot(7'(sy), 8'(sx), pix_data);
                    end else begin
                        ctr_adv = 1'b1;
                        state_d = last_c ? ST_DONE : ST_FETCH;
                    end
`endif
                end
            end
            ST_WRITE: begin
                if (!vga_waitrequest) begin
`ifdef VGA_BLIT_SCALE2_EN
                    if (rem_c != 4'b0000) begin
                        mask_d  = rem_c;
                        wdata_d = sub_word(bx_q, by_q, low_idx(rem_c), pix_q);
                    end else begin
                        mask_d  = 4'b0000;
                        ctr_adv = 1'b1;
                        state_d = last_c ? ST_DONE : ST_FETCH;
                    end
`else
                    ctr_adv = 1'b1;
                    state_d = last_c ? ST_DONE : ST_FETCH;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_FETCH) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_FETCH);
        write_d = (state_d == ST_WRITE);
    end

    // Registered outputs, origin latch and write payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
            vga_write <= 1'b0;
            wdata_q   <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            pix_ready <= ready_d;
            vga_write <= write_d;
            wdata_q   <= wdata_d;
            if (org_ld) begin
                x0_q <= x0;
                y0_q <= y0;
            end
        end
    end

endmodule

// File: tb/tb_vga_blit_master.sv
// Self-checking bench for vga_blit_master (4x4 image); follows
// VGA_BLIT_SCALE2_EN when defined.
module tb_vga_blit_master;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic        busy, done;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [3:0]  vga_address;
    logic        vga_write;
    logic [31:0] vga_writedata;
    logic        vga_waitrequest = 1'b0;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  pix[N];
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int wr_done = 0;
    int stall_total = 0;
    int stall_at = -100;
    int stall_len = 0;
    int stall_cnt = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] held_data = '0;

    vga_blit_master #(.IMG_W(W), .IMG_H(H)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .x0              (x0),
        .y0              (y0),
        .busy            (busy),
        .done            (done),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .vga_address     (vga_address),
        .vga_write       (vga_write),
        .vga_writedata   (vga_writedata),
        .vga_waitrequest (vga_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] plot(input int x, input int y, input logic [7:0] b);
        return {1'b0, 7'(y), 8'(x), 8'h00, b};
    endfunction

    // Reference model: queue the writes the whole image should produce
    task automatic push_image(input int ox, input int oy, output int n);
        n = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
`ifdef VGA_BLIT_SCALE2_EN
                for (int s = 0; s < 4; s++) begin
                    int x, y;
                    x = ox + 2 * c + (s % 2);
                    y = oy + 2 * r + (s / 2);
                    if (x < 160 && y < 120) begin
                        exp_q.push_back(plot(x, y, pix[r * W + c]));
                        n++;
                    end
                end
`else
                if (ox + c < 160 && oy + r < 120) begin
                    exp_q.push_back(plot(ox + c, oy + r, pix[r * W + c]));
                    n++;
                end
`endif
            end
        end
    endtask

    // Bus monitor / waitrequest driver / scoreboard checker
    always @(negedge clk) begin
        if (reset) begin
            stalled_prev    = 1'b0;
            stall_cnt       = 0;
            vga_waitrequest = 1'b0;
        end else begin
            if (stalled_prev) begin
                tests++;
                if (vga_write !== 1'b1 || vga_writedata !== held_data || pix_ready !== 1'b0) begin
                    failed++;
                    $display("FAIL stall_hold: write=%b data=%h ready=%b, required write=1 data=%h ready=0",
                             vga_write, vga_writedata, pix_ready, held_data);
                end
            end
            if (vga_write === 1'b1 && wr_done == stall_at && stall_cnt < stall_len) begin
                vga_waitrequest = 1'b1;
                stall_cnt++;
                stall_total++;
            end else begin
                vga_waitrequest = 1'b0;
            end
            if (vga_write === 1'b1 && vga_waitrequest == 1'b0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_write: data=%h, required no write", vga_writedata);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (vga_writedata !== e || vga_address !== 4'd0) begin
                        failed++;
                        $display("FAIL write_data: addr=%h data=%h, required addr=0 data=%h",
                                 vga_address, vga_writedata, e);
                    end
                end
                wr_done++;
                stall_cnt = 0;
            end
            stalled_prev = vga_write && vga_waitrequest;
            held_data    = vga_writedata;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                tests++;
                if (busy !== 1'b0) begin
                    failed++;
                    $display("FAIL done_busy: busy=%b during done, required 0", busy);
                end
            end
        end
    end

    // Source driver: deliver pixels first..first+n-1 with valid/ready handshake
    task automatic feed(input int first, input int n, input bit toggle, input bit chk_busy);
        int idx, taken, cl;
        idx = first; taken = 0; cl = 0;
        while (taken < n && cl < 600) begin
            @(negedge clk);
            cl++;
            if (chk_busy) begin
                tests++;
                if (busy !== 1'b1) begin
                    failed++;
                    $display("FAIL busy_high: busy=%b at cycle %0d, required 1", busy, cl);
                end
            end
            if (toggle && cl[0]) pix_valid = 1'b0;
            else begin
                pix_valid = 1'b1;
                pix_data  = pix[idx];
            end
            if (pix_valid && pix_ready) begin
                idx++;
                taken++;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        tests++;
        if (taken != n) begin
            failed++;
            $display("FAIL feed_count: accepted %0d pixels, required %0d", taken, n);
        end
    endtask

    task automatic run_blit(input int ox, input int oy, input bit toggle, input int n);
        fork
            begin
                @(negedge clk);
                x0 = 8'(ox); y0 = 7'(oy); start = 1'b1; start_cyc = cyc;
                @(negedge clk);
                start = 1'b0;
            end
            begin
                @(negedge clk);
                feed(0, n, toggle, 1'b1);
            end
        join
    endtask

    task automatic wait_done(input int base, input string name);
        int k;
        k = 0;
        while (done_cnt == base && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt != base + 1) begin
            failed++;
            $display("FAIL %s_done: %0d done pulses, required 1", name, done_cnt - base);
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL %s_pending: %0d writes missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, pix_ready, vga_write} !== 4'b0000 || vga_address !== 4'd0 || vga_writedata !== 32'd0) begin
            failed++;
            $display("FAIL reset_values: busy=%b done=%b ready=%b write=%b addr=%h data=%h, required all 0",
                     busy, done, pix_ready, vga_write, vga_address, vga_writedata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || pix_ready !== 1'b0) begin
            failed++;
            $display("FAIL idle_after_reset: busy=%b ready=%b, required 0 0", busy, pix_ready);
        end
    endtask

    task automatic test_basic;
        int n, base, dcyc;
        for (int i = 0; i < N; i++) pix[i] = 8'(i + 1);
        push_image(0, 0, n);
        base = done_cnt;
        run_blit(0, 0, 1'b0, N);
        wait_done(base, "basic");
`ifdef VGA_BLIT_SCALE2_EN
        dcyc = 1 + 5 * N;
`else
        dcyc = 1 + 2 * N;
`endif
        tests++;
        if (done_cyc - start_cyc != dcyc) begin
            failed++;
            $display("FAIL basic_latency: %0d cycles, required %0d", done_cyc - start_cyc, dcyc);
        end
    endtask

    task automatic test_stall;
        int n, base, sbase;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'hA0 + i);
        push_image(3, 5, n);
        base      = done_cnt;
        sbase     = stall_total;
        stall_at  = wr_done + 2;
        stall_len = 5;
        run_blit(3, 5, 1'b0, N);
        wait_done(base, "stall");
        stall_at = -100;
        tests++;
        if (stall_total - sbase != 5) begin
            failed++;
            $display("FAIL stall_cycles: %0d stalled cycles, required 5", stall_total - sbase);
        end
    endtask

    task automatic test_clip;
        int n, base, wbase;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'h40 + 3 * i);
        push_image(158, 118, n);
        base  = done_cnt;
        wbase = wr_done;
        run_blit(158, 118, 1'b0, N);
        wait_done(base, "clip");
        tests++;
        if (wr_done - wbase != 4) begin
            failed++;
            $display("FAIL clip_count: %0d writes, required 4", wr_done - wbase);
        end
    endtask

    task automatic test_backpressure;
        int n, base;
        for (int i = 0; i < N; i++) pix[i] = 8'((i * 37) & 8'hFF);
        pix[0] = 8'h00;
        push_image(10, 20, n);
        base = done_cnt;
        run_blit(10, 20, 1'b1, N);
        wait_done(base, "backpressure");
    endtask

    task automatic test_back_to_back;
        int n, base;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'hF0 - i);
        push_image(150, 0, n);
        base = done_cnt;
        run_blit(150, 0, 1'b0, N);
        wait_done(base, "b2b_first");
        push_image(0, 110, n);
        base = done_cnt;
        run_blit(0, 110, 1'b0, N);
        wait_done(base, "b2b_second");
    endtask

    task automatic test_start_busy_reset;
        int n, base;
        for (int i = 0; i < N; i++) pix[i] = 8'(8'h11 * (i % 15) + 1);
        push_image(0, 0, n);
        run_blit(0, 0, 1'b0, 5);
        @(negedge clk);
        x0 = 8'd50; y0 = 7'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(5, 3, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || vga_write !== 1'b0 || pix_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid: busy=%b write=%b ready=%b, required 0 0 0", busy, vga_write, pix_ready);
        end
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        push_image(5, 7, n);
        base = done_cnt;
        run_blit(5, 7, 1'b0, N);
        wait_done(base, "after_reset");
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        x0        = '0;
        y0        = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
        test_reset();
        test_basic();
        test_stall();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_start_busy_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
